// File: rtl/seq_alu_if.sv
// Execute-stage ALU bus: operands and opcode from the datapath, result and stall/done back to it.
interface seq_alu_if #(
  parameter int WIDTH = 32
);
  logic [WIDTH-1:0] SrcA;
  logic [WIDTH-1:0] SrcB;
  logic [2:0]       ALUControl;
  logic             Start;
  logic [WIDTH-1:0] ALUResult;
  logic             Zero;
  logic             Busy;
  logic             Done;

  modport master (
    output SrcA, SrcB, ALUControl, Start,
    input  ALUResult, Zero, Busy, Done
  );

  modport slave (
    input  SrcA, SrcB, ALUControl, Start,
    output ALUResult, Zero, Busy, Done
  );
endinterface

// File: rtl/seq_alu.sv
// Execute-stage ALU: single-cycle and/or/add/sub/slt plus an optional 32-step shift-add multiplier.
// The multiplier FSM exists only when SEQ_ALU_MUL_EN is defined; otherwise code 101 acts as add.
module seq_alu #(
  parameter int WIDTH = 32
) (
  input logic     clk,
  input logic     rst_n,
  seq_alu_if.slave bus
);

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b100;
  localparam logic [2:0] OP_SLT = 3'b110;
  localparam logic [2:0] OP_MUL = 3'b101;

  logic [WIDTH-1:0] sum_s;
  logic [WIDTH-1:0] diff_s;
  logic             slt_s;
  logic [WIDTH-1:0] comb_res_s;
  logic [WIDTH-1:0] result_s;
  logic             busy_s;
  logic             done_s;

  assign sum_s  = bus.SrcA + bus.SrcB;
  assign diff_s = bus.SrcA - bus.SrcB;
  assign slt_s  = ($signed(bus.SrcA) < $signed(bus.SrcB));

  // Zero-latency opcode decode; unused codes fall through to add.
  always_comb begin
    comb_res_s = sum_s;
    case (bus.ALUControl)
      OP_AND:  comb_res_s = bus.SrcA & bus.SrcB;
      OP_OR:   comb_res_s = bus.SrcA | bus.SrcB;
      OP_ADD:  comb_res_s = sum_s;
      OP_SUB:  comb_res_s = diff_s;
      OP_SLT:  comb_res_s = {{(WIDTH-1){1'b0}}, slt_s};
`ifdef SEQ_ALU_MUL_EN
      OP_MUL:  comb_res_s = {WIDTH{1'b0}};
`else
      OP_MUL:  comb_res_s = sum_s;
`endif
      default: comb_res_s = sum_s;
    endcase
  end

`ifdef SEQ_ALU_MUL_EN
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int            CW        = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);

  state_t           state_r;
  logic [WIDTH-1:0] acc_r;
  logic [WIDTH-1:0] mcand_r;
  logic [WIDTH-1:0] mplier_r;
  logic [CW-1:0]    cnt_r;
  logic             launch_s;

  assign launch_s = (state_r == IDLE) && bus.Start && (bus.ALUControl == OP_MUL);

  // Multiply sequencer: latch operands, one shift-add per cycle, one DONE cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= IDLE;
      acc_r    <= {WIDTH{1'b0}};
      mcand_r  <= {WIDTH{1'b0}};
      mplier_r <= {WIDTH{1'b0}};
      cnt_r    <= {CW{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          if (launch_s) begin
            state_r  <= MUL;
            mcand_r  <= bus.SrcA;
            mplier_r <= bus.SrcB;
            acc_r    <= {WIDTH{1'b0}};
            cnt_r    <= {CW{1'b0}};
          end
        end
        MUL: begin
          if (mplier_r[0]) begin
            acc_r <= acc_r + mcand_r;
          end
          mcand_r  <= mcand_r << 1;
          mplier_r <= mplier_r >> 1;
          cnt_r    <= cnt_r + CNT_ONE;
          if (cnt_r == LAST_ITER) begin
            state_r <= DONE;
          end
        end
        DONE:    state_r <= IDLE;
        default: state_r <= IDLE;
      endcase
    end
  end

  // Stall is raised in the launch cycle itself so PC/writeback hold immediately.
  always_comb begin
    result_s = comb_res_s;
    if (state_r == DONE) begin
      result_s = acc_r;
    end else begin
      result_s = comb_res_s;
    end
    busy_s = rst_n && (launch_s || (state_r == MUL));
    done_s = rst_n && (state_r == DONE);
  end
`else
  logic unused_s;

  assign unused_s = clk ^ rst_n ^ bus.Start;

  // Purely combinational build: no stall, no completion pulse.
  always_comb begin
    result_s = comb_res_s;
    busy_s   = 1'b0;
    done_s   = 1'b0;
  end
`endif

  assign bus.ALUResult = result_s;
  assign bus.Zero      = (result_s == {WIDTH{1'b0}});
  assign bus.Busy      = busy_s;
  assign bus.Done      = done_s;

endmodule

// File: tb/tb_seq_alu.sv
// Directed bench for seq_alu; multiply checks apply when SEQ_ALU_MUL_EN is defined.
module tb_seq_alu;

  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_pass;
  int   cyc;

  seq_alu_if #(.WIDTH(32)) ifc ();

  seq_alu #(.WIDTH(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifc.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk = n_chk + 1;
    if (obs === exp) begin
      n_pass = n_pass + 1;
    end else begin
      $display("FAIL %s: got 0x%08h, want 0x%08h", tag, obs, exp);
    end
  endtask

  // Apply inputs just after a rising edge, then sample at the following falling edge.
  task automatic apply(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op,
                       input logic st);
    @(posedge clk);
    #1;
    ifc.SrcA       = a;
    ifc.SrcB       = b;
    ifc.ALUControl = op;
    ifc.Start      = st;
    @(negedge clk);
  endtask

  task automatic comb_vec(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic [2:0] op, input logic [31:0] exp);
    apply(a, b, op, 1'b1);
    chk(tag, ifc.ALUResult, exp);
    chk({tag, "_zero"}, {31'd0, ifc.Zero}, {31'd0, exp == 32'd0});
    chk({tag, "_busy"}, {31'd0, ifc.Busy}, 32'd0);
  endtask

`ifdef SEQ_ALU_MUL_EN
  // Launch a multiply at T0 and check stall/done/result through T33.
  task automatic run_mul(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp, input logic poke);
    int busy_bad;
    int done_bad;
    busy_bad = 0;
    done_bad = 0;
    apply(a, b, 3'b101, 1'b1);
    chk({tag, "_busy_t0"}, {31'd0, ifc.Busy}, 32'd1);
    chk({tag, "_res_t0"}, ifc.ALUResult, 32'd0);
    for (int t = 1; t <= 32; t++) begin
      @(posedge clk);
      #1;
      ifc.Start = 1'b0;
      if (poke && t == 5) begin
        ifc.SrcA       = 32'd0;
        ifc.SrcB       = 32'd0;
        ifc.ALUControl = 3'b000;
      end
      @(negedge clk);
      if (ifc.Busy !== 1'b1) busy_bad = busy_bad + 1;
      if (ifc.Done !== 1'b0) done_bad = done_bad + 1;
    end
    chk({tag, "_busy_t1_t32_low_count"}, busy_bad, 32'd0);
    chk({tag, "_done_early_count"}, done_bad, 32'd0);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk({tag, "_done_t33"}, {31'd0, ifc.Done}, 32'd1);
    chk({tag, "_busy_t33"}, {31'd0, ifc.Busy}, 32'd0);
    chk({tag, "_res_t33"}, ifc.ALUResult, exp);
    chk({tag, "_zero_t33"}, {31'd0, ifc.Zero}, {31'd0, exp == 32'd0});
    apply(32'd0, 32'd0, 3'b010, 1'b0);
    chk({tag, "_done_t34"}, {31'd0, ifc.Done}, 32'd0);
  endtask
`endif

  initial begin
    int t0;
    int n_done;
    int first_done;
    int second_done;
    n_chk          = 0;
    n_pass         = 0;
    cyc            = 0;
    rst_n          = 1'b0;
    ifc.SrcA       = 32'd5;
    ifc.SrcB       = 32'd3;
    ifc.ALUControl = 3'b010;
    ifc.Start      = 1'b0;

    #12;
    chk("rst_add", ifc.ALUResult, 32'd8);
    chk("rst_busy", {31'd0, ifc.Busy}, 32'd0);
    chk("rst_done", {31'd0, ifc.Done}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    comb_vec("add_ovf", 32'h7FFF_FFFF, 32'd1, 3'b010, 32'h8000_0000);
    comb_vec("sub_eq", 32'd9, 32'd9, 3'b100, 32'd0);
    comb_vec("sub_wrap", 32'd0, 32'd1, 3'b100, 32'hFFFF_FFFF);
    comb_vec("slt_m1_1", 32'hFFFF_FFFF, 32'd1, 3'b110, 32'd1);
    comb_vec("slt_1_m1", 32'd1, 32'hFFFF_FFFF, 3'b110, 32'd0);
    comb_vec("and", 32'h0000_F0F0, 32'h0000_FF00, 3'b000, 32'h0000_F000);
    comb_vec("or", 32'h0000_F0F0, 32'h0000_FF00, 3'b001, 32'h0000_FFF0);
    comb_vec("op011", 32'd20, 32'd22, 3'b011, 32'd42);
    comb_vec("op111", 32'hFFFF_FFFF, 32'd2, 3'b111, 32'd1);

`ifdef SEQ_ALU_MUL_EN
    apply(32'd6, 32'd7, 3'b101, 1'b0);
    chk("mul_nostart_res", ifc.ALUResult, 32'd0);
    chk("mul_nostart_busy", {31'd0, ifc.Busy}, 32'd0);

    run_mul("mul_basic", 32'h0000_1234, 32'h0000_0100, 32'h0012_3400, 1'b0);
    run_mul("mul_neg", 32'hFFFF_FFFF, 32'd7, 32'hFFFF_FFF9, 1'b0);
    run_mul("mul_poke", 32'h0000_1234, 32'h0000_0100, 32'h0012_3400, 1'b1);

    // Back-to-back: Start held with mul throughout, Done expected at T33 and T67.
    n_done      = 0;
    first_done  = -1;
    second_done = -1;
    @(posedge clk);
    #1;
    ifc.SrcA       = 32'd3;
    ifc.SrcB       = 32'd5;
    ifc.ALUControl = 3'b101;
    ifc.Start      = 1'b1;
    t0             = cyc;
    for (int i = 0; i < 75; i++) begin
      @(negedge clk);
      if (ifc.Done === 1'b1) begin
        n_done = n_done + 1;
        if (first_done < 0) first_done = cyc;
        else if (second_done < 0) second_done = cyc;
        chk("b2b_res", ifc.ALUResult, 32'd15);
      end
    end
    chk("b2b_pulses", n_done, 32'd2);
    chk("b2b_first", first_done - t0, 32'd33);
    chk("b2b_gap", second_done - first_done, 32'd34);
    apply(32'd0, 32'd0, 3'b010, 1'b0);

    // Reset in T10 of a multiply aborts it.
    apply(32'h0000_1234, 32'h0000_0100, 3'b101, 1'b1);
    chk("abort_busy_t0", {31'd0, ifc.Busy}, 32'd1);
    repeat (10) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(negedge clk);
    chk("abort_busy_rst", {31'd0, ifc.Busy}, 32'd0);
    chk("abort_done_rst", {31'd0, ifc.Done}, 32'd0);
    apply(32'd2, 32'd2, 3'b010, 1'b0);
    rst_n = 1'b1;
    #1;
    chk("abort_add", ifc.ALUResult, 32'd4);
    chk("abort_add_busy", {31'd0, ifc.Busy}, 32'd0);
    n_done = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (ifc.Done === 1'b1 || ifc.Busy === 1'b1) n_done = n_done + 1;
    end
    chk("abort_no_done", n_done, 32'd0);
`else
    apply(32'd6, 32'd7, 3'b101, 1'b1);
    chk("mul_as_add", ifc.ALUResult, 32'd13);
    chk("mul_busy", {31'd0, ifc.Busy}, 32'd0);
    n_done = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (ifc.Done === 1'b1 || ifc.Busy === 1'b1) n_done = n_done + 1;
    end
    chk("mul_no_seq", n_done, 32'd0);
    rst_n = 1'b0;
    apply(32'd2, 32'd2, 3'b101, 1'b1);
    chk("rst_mul_as_add", ifc.ALUResult, 32'd4);
    chk("rst_mul_busy", {31'd0, ifc.Busy}, 32'd0);
    rst_n = 1'b1;
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
